axil_mem_master: RTL and testbench
==================================

Name: axil_mem_master

Overview:
- Parametrised, two-channel AXI4-Lite master that succeeds the single-port core memory interface.
- Serves an instruction-fetch channel and a load/store data channel through one AXI4-Lite port.
- Arbitrates the two channels round-robin and handles byte/half/word (and dword when DATA_W=64) lanes with sign/zero extension.
- Detects misalignment, reports bus errors, and applies a response-phase timeout.
- Sits between the core FSM/datapath and the system interconnect.

Parameters:
- ADDR_W, 32, address width of requests and AW/AR channels.
- DATA_W, 32, bus data width; legal values are 32 and 64.
- TIMEOUT, 255, maximum cycles waited in a response phase before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- f_valid  in  1  fetch request valid
- f_addr  in  ADDR_W  fetch address; access is always a 32-bit read
- f_ready  out  1  fetch request accepted this cycle
- d_valid  in  1  data request valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_size  in  2  00 byte, 01 half, 10 word, 11 dword
- d_sign  in  1  sign-extend load result
- d_wdata  in  DATA_W  store data, right-aligned
- d_ready  out  1  data request accepted this cycle
- resp_valid  out  1  one-cycle response strobe
- resp_ch  out  1  0 = fetch, 1 = data
- resp_rdata  out  DATA_W  extended load or fetch data; 0 for stores and errors
- resp_err  out  2  00 ok, 01 bus error, 10 misaligned, 11 timeout
- awaddr, awvalid, awready, awprot  AXI4-Lite write-address channel (awaddr ADDR_W, awprot 3)
- wdata, wstrb, wvalid, wready  AXI4-Lite write-data channel (wdata DATA_W, wstrb DATA_W/8)
- bresp, bvalid, bready  AXI4-Lite write-response channel
- araddr, arvalid, arready, arprot  AXI4-Lite read-address channel (araddr ADDR_W, arprot 3)
- rdata, rresp, rvalid, rready  AXI4-Lite read-data channel

Behaviour:
- Reset (rstn=0 at posedge, also mid-transaction):
  - state to IDLE; all AXI valid/ready outputs 0; resp_valid 0; resp_* 0; f_ready/d_ready 0.
  - Timeout counter 0; round-robin pointer prefers fetch.
- States: IDLE, AR, R, AW_W, B, ERR, RESP.
- IDLE, request acceptance:
  - f_ready/d_ready are combinational and only one is high: the grantee among the valid channels.
  - Ties go to the channel not granted last.
  - Acceptance latches address, size, sign, we, wdata and channel.
- IDLE, next state:
  - Misaligned request (addr mod access-bytes != 0, or d_size=11 with DATA_W=32) -> ERR. No AXI activity.
  - Otherwise load/fetch -> AR, store -> AW_W.
- Address-phase timing: AXI valids are registered and rise the cycle after acceptance.
- AR: arvalid=1 held until arready; araddr = latched address aligned down to DATA_W/8. Then -> R.
- R: rready=1 until rvalid; latch rdata/rresp; -> RESP.
- AW_W:
  - awvalid and wvalid rise together; each drops independently on its own ready.
  - Leave for B only when both handshakes have completed (either order, or the same cycle).
  - wdata = store data replicated across all lanes.
  - wstrb = size mask shifted by addr low bits (byte at offset 3 on a 32-bit bus -> 1000).
- B: bready=1 until bvalid; latch bresp; -> RESP.
- Timeout:
  - Counter runs only in R and B, cleared on entry. Address phases wait indefinitely (AXI forbids dropping valid).
  - Counter reaching TIMEOUT before rvalid/bvalid: drop ready, resp_err=11 -> RESP.
  - A late rvalid/bvalid arriving in IDLE is ignored.
- ERR: one cycle -> RESP with resp_err=10.
- RESP:
  - resp_valid=1 for exactly one cycle; -> IDLE. No new request is accepted in RESP.
  - Minimum request-to-response latency with zero-wait slave: accept N, arvalid N+1, rvalid N+2, resp_valid N+3.
- Read extraction:
  - Select the lane at addr low bits.
  - Byte/half/word: sign-extend if d_sign, else zero-extend, to DATA_W.
  - Fetch: zero-extended word.
- resp_err=01 when rresp/bresp != 00; resp_rdata is 0 on any error.
- Protection: arprot = 100 for fetch, 000 for data; awprot = 000.

Test Plan:
- Fetch 0x0000_0008, slave returns rdata 0x0010_0093 with zero wait -> arvalid at N+1, araddr 0x8, arprot 100; resp_valid at N+3, resp_ch 0, resp_rdata 0x0010_0093, err 00.
- Signed byte load at 0x103 with rdata 0x8000_0000 -> resp_rdata 0xFFFF_FF80. Same load with d_sign=0 -> 0x0000_0080.
- Half store of 0x1234 to 0x202, wready 3 cycles after awready -> wdata 0x1234_1234, wstrb 1100; single resp err 00 after bvalid.
- Word load at 0x101 -> no arvalid ever; resp_err 10 two cycles after acceptance.
- f_valid and d_valid both held high -> grants alternate fetch, data, fetch; each gets a response, no starvation.
- TIMEOUT=4, rvalid never arrives -> rready drops after 4 cycles in R, resp_err 11. Reset asserted mid-AW_W -> awvalid/wvalid 0 next cycle, state IDLE.

Source files
------------

// File: rtl/axil_mem_master.sv
// Two-channel (fetch + load/store) AXI4-Lite master with round-robin arbitration,
// lane extraction/extension, misalignment detection and response-phase timeout.
module axil_mem_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    // fetch channel
    input  logic                  f_valid,
    input  logic [ADDR_W-1:0]     f_addr,
    output logic                  f_ready,
    // data channel
    input  logic                  d_valid,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [1:0]            d_size,
    input  logic                  d_sign,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ready,
    // response
    output logic                  resp_valid,
    output logic                  resp_ch,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic [1:0]            resp_err,
    // AXI4-Lite write address
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [2:0]            awprot,
    // AXI4-Lite write data
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    // AXI4-Lite write response
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AXI4-Lite read address
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [2:0]            arprot,
    // AXI4-Lite read data
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {StIdle, StAr, StR, StAwW, StB, StErr, StResp} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ch_q, ch_d;
    logic                pref_d_q, pref_d_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          err_q, err_d;

    logic                gnt_f, gnt_d, f_mis, d_mis, timeout_hit;
    logic [OffW-1:0]     off;
    logic [DATA_W-1:0]   rd_lane, rd_mask, rd_ext;
    logic                rd_msb;
    logic [StrbW-1:0]    strb_mask;

    assign off = addr_q[OffW-1:0];

    // Tie goes to whichever channel was not granted last; reset prefers fetch.
    assign gnt_f = rstn && (state_q == StIdle) && f_valid && (!d_valid || !pref_d_q);
    assign gnt_d = rstn && (state_q == StIdle) && d_valid && (!f_valid || pref_d_q);

    assign f_mis = |f_addr[1:0];
    always_comb begin
        d_mis = 1'b0;
        case (d_size)
            2'b00:   d_mis = 1'b0;
            2'b01:   d_mis = d_addr[0];
            2'b10:   d_mis = |d_addr[1:0];
            default: d_mis = (DATA_W == 32) || (|d_addr[2:0]);
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

    // Load lane extraction with sign/zero extension to the full bus width.
    always_comb begin
        rd_lane = rdata >> {off, 3'b000};
        rd_mask = '1;
        rd_msb  = 1'b0;
        case (size_q)
            2'b00: begin rd_mask = DATA_W'(8'hFF);         rd_msb = rd_lane[7];  end
            2'b01: begin rd_mask = DATA_W'(16'hFFFF);      rd_msb = rd_lane[15]; end
            2'b10: begin rd_mask = DATA_W'(32'hFFFF_FFFF); rd_msb = rd_lane[31]; end
            default: begin rd_mask = '1;                   rd_msb = 1'b0;        end
        endcase
        rd_ext = (rd_lane & rd_mask) | ((sign_q && rd_msb) ? ~rd_mask : '0);
    end

    always_comb begin
        strb_mask = '0;
        wdata     = wdata_q;
        case (size_q)
            2'b00: begin strb_mask = StrbW'(1);  wdata = {StrbW{wdata_q[7:0]}};         end
            2'b01: begin strb_mask = StrbW'(3);  wdata = {(StrbW / 2){wdata_q[15:0]}};  end
            2'b10: begin strb_mask = StrbW'(15); wdata = {(DATA_W / 32){wdata_q[31:0]}}; end
            default: begin strb_mask = '1;       wdata = wdata_q;                       end
        endcase
    end

    assign wstrb   = strb_mask << off;
    assign araddr  = {addr_q[ADDR_W-1:OffW], OffW'(0)};
    assign awaddr  = {addr_q[ADDR_W-1:OffW], OffW'(0)};
    assign arprot  = ch_q ? 3'b000 : 3'b100;
    assign awprot  = 3'b000;
    assign arvalid = (state_q == StAr);
    assign rready  = (state_q == StR) && !timeout_hit;
    assign awvalid = (state_q == StAwW) && !aw_done_q;
    assign wvalid  = (state_q == StAwW) && !w_done_q;
    assign bready  = (state_q == StB) && !timeout_hit;
    assign f_ready = gnt_f;
    assign d_ready = gnt_d;

    assign resp_valid = (state_q == StResp);
    assign resp_ch    = resp_valid && ch_q;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid ? err_q : 2'b00;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        sign_d    = sign_q;
        wdata_d   = wdata_q;
        ch_d      = ch_q;
        pref_d_d  = pref_d_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        cnt_d     = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            StIdle: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (gnt_f) begin
                    addr_d   = f_addr;
                    size_d   = 2'b10;
                    sign_d   = 1'b0;
                    ch_d     = 1'b0;
                    pref_d_d = 1'b1;
                    state_d  = f_mis ? StErr : StAr;
                end else if (gnt_d) begin
                    addr_d   = d_addr;
                    size_d   = d_size;
                    sign_d   = d_sign;
                    wdata_d  = d_wdata;
                    ch_d     = 1'b1;
                    pref_d_d = 1'b0;
                    state_d  = d_mis ? StErr : (d_we ? StAwW : StAr);
                end
            end
            StAr: begin
                if (arready) state_d = StR;
            end
            StR: begin
                if (timeout_hit) begin
                    err_d   = 2'b11;
                    rdata_d = '0;
                    state_d = StResp;
                end else if (rvalid) begin
                    err_d   = (rresp != 2'b00) ? 2'b01 : 2'b00;
                    rdata_d = (rresp != 2'b00) ? '0 : rd_ext;
                    state_d = StResp;
                end else begin
                    cnt_d = (TIMEOUT == 0) ? '0 : cnt_q + 1'b1;
                end
            end
            StAwW: begin
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) state_d = StB;
            end
            StB: begin
                if (timeout_hit) begin
                    err_d   = 2'b11;
                    rdata_d = '0;
                    state_d = StResp;
                end else if (bvalid) begin
                    err_d   = (bresp != 2'b00) ? 2'b01 : 2'b00;
                    rdata_d = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = (TIMEOUT == 0) ? '0 : cnt_q + 1'b1;
                end
            end
            StErr: begin
                err_d   = 2'b10;
                rdata_d = '0;
                state_d = StResp;
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            size_q    <= 2'b00;
            sign_q    <= 1'b0;
            wdata_q   <= '0;
            ch_q      <= 1'b0;
            pref_d_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            wdata_q   <= wdata_d;
            ch_q      <= ch_d;
            pref_d_q  <= pref_d_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_axil_mem_master.sv
// Directed bench for axil_mem_master: fetch/load/store paths, arbitration, errors, timeout, reset.
module tb_axil_mem_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        f_valid, f_ready, d_valid, d_we, d_sign, d_ready;
    logic [31:0] f_addr, d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        resp_valid, resp_ch;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int n_tests = 0;
    int n_fail  = 0;
    logic chseq [3] = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    axil_mem_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_sign(d_sign),
        .d_wdata(d_wdata), .d_ready(d_ready),
        .resp_valid(resp_valid), .resp_ch(resp_ch), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awprot(awprot),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arprot(arprot),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic sign, input logic [31:0] rd, input logic [1:0] rr,
                        input logic [31:0] exp_ar, input logic [31:0] exp_rd,
                        input logic [1:0] exp_err);
        d_valid = 1'b1; d_we = 1'b0; d_addr = addr; d_size = size; d_sign = sign;
        #1;
        chk({tag, ".d_ready"}, d_ready, 1'b1);
        tick();
        d_valid = 1'b0;
        chk({tag, ".arvalid"}, arvalid, 1'b1);
        chk({tag, ".araddr"}, araddr, exp_ar);
        chk({tag, ".arprot"}, arprot, 3'b000);
        tick();
        rvalid = 1'b1; rdata = rd; rresp = rr;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        chk({tag, ".resp_valid"}, resp_valid, 1'b1);
        chk({tag, ".resp_ch"}, resp_ch, 1'b1);
        chk({tag, ".resp_rdata"}, resp_rdata, exp_rd);
        chk({tag, ".resp_err"}, resp_err, exp_err);
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        f_valid = 1'b1; f_addr = 32'h0; d_valid = 1'b1; d_we = 1'b0; d_addr = 32'h0;
        d_size = 2'b10; d_sign = 1'b0; d_wdata = 32'h0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b1; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
        tick(); tick();
        #1;
        chk("reset.ctrl", {f_ready, d_ready, arvalid, awvalid, wvalid, rready, bready,
                           resp_valid}, 8'h00);
        chk("reset.resp", {resp_err, resp_rdata, resp_ch}, 35'h0);
        f_valid = 1'b0; d_valid = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // Fetch with zero-wait slave: accept N, arvalid N+1, rvalid N+2, resp N+3.
        f_valid = 1'b1; f_addr = 32'h0000_0008;
        #1;
        chk("fetch.f_ready", f_ready, 1'b1);
        chk("fetch.d_ready", d_ready, 1'b0);
        tick();
        f_valid = 1'b0;
        chk("fetch.arvalid", arvalid, 1'b1);
        chk("fetch.araddr", araddr, 32'h8);
        chk("fetch.arprot", arprot, 3'b100);
        chk("fetch.resp_n1", resp_valid, 1'b0);
        tick();
        chk("fetch.arvalid_low", arvalid, 1'b0);
        chk("fetch.rready", rready, 1'b1);
        rvalid = 1'b1; rdata = 32'h0010_0093;
        tick();
        rvalid = 1'b0;
        chk("fetch.resp_valid", resp_valid, 1'b1);
        chk("fetch.resp_ch", resp_ch, 1'b0);
        chk("fetch.resp_rdata", resp_rdata, 32'h0010_0093);
        chk("fetch.resp_err", resp_err, 2'b00);
        tick();
        chk("fetch.resp_once", resp_valid, 1'b0);

        load("lb_s", 32'h103, 2'b00, 1'b1, 32'h8000_0000, 2'b00, 32'h100, 32'hFFFF_FF80, 2'b00);
        load("lb_u", 32'h103, 2'b00, 1'b0, 32'h8000_0000, 2'b00, 32'h100, 32'h0000_0080, 2'b00);
        load("lh_s", 32'h102, 2'b01, 1'b1, 32'h8001_0000, 2'b00, 32'h100, 32'hFFFF_8001, 2'b00);
        load("lw",   32'h104, 2'b10, 1'b1, 32'hDEAD_BEEF, 2'b00, 32'h104, 32'hDEAD_BEEF, 2'b00);
        load("lberr",32'h109, 2'b00, 1'b0, 32'h1234_5678, 2'b10, 32'h108, 32'h0, 2'b01);

        // Half store, wready three cycles after awready.
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h202; d_size = 2'b01; d_wdata = 32'h1234;
        awready = 1'b1;
        #1;
        chk("sh.d_ready", d_ready, 1'b1);
        tick();
        d_valid = 1'b0; d_we = 1'b0;
        chk("sh.aw_w_valid", {awvalid, wvalid}, 2'b11);
        chk("sh.awaddr", awaddr, 32'h200);
        chk("sh.wdata", wdata, 32'h1234_1234);
        chk("sh.wstrb", wstrb, 4'b1100);
        chk("sh.awprot", awprot, 3'b000);
        tick();
        awready = 1'b0;
        chk("sh.aw_drop", {awvalid, wvalid}, 2'b01);
        tick();
        chk("sh.w_hold", {awvalid, wvalid, bready}, 3'b010);
        tick();
        wready = 1'b1;
        chk("sh.w_hold2", {awvalid, wvalid, bready}, 3'b010);
        tick();
        wready = 1'b0;
        chk("sh.in_b", {wvalid, bready, resp_valid}, 3'b010);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("sh.resp", {resp_valid, resp_ch, resp_err}, 4'b1100);
        chk("sh.resp_rdata", resp_rdata, 32'h0);
        tick();
        chk("sh.resp_once", resp_valid, 1'b0);

        // Misaligned word load, then dword on a 32-bit bus.
        d_valid = 1'b1; d_addr = 32'h101; d_size = 2'b10;
        #1;
        chk("mis.d_ready", d_ready, 1'b1);
        tick();
        d_valid = 1'b0;
        chk("mis.n1", {arvalid, awvalid, resp_valid}, 3'b000);
        tick();
        chk("mis.resp", {arvalid, resp_valid, resp_err}, 4'b0110);
        chk("mis.rdata", resp_rdata, 32'h0);
        tick();
        d_valid = 1'b1; d_addr = 32'h0; d_size = 2'b11;
        tick();
        d_valid = 1'b0;
        chk("dw32.n1", {arvalid, resp_valid}, 2'b00);
        tick();
        chk("dw32.resp", {resp_valid, resp_err}, 3'b110);
        tick();

        // Both channels requesting: grants alternate fetch, data, fetch.
        f_addr = 32'h10; d_addr = 32'h20; d_size = 2'b10; d_sign = 1'b0;
        for (int i = 0; i < 3; i++) begin
            f_valid = 1'b1; d_valid = 1'b1;
            #1;
            chk("arb.f_ready", f_ready, !chseq[i]);
            chk("arb.d_ready", d_ready, chseq[i]);
            tick();
            chk("arb.arprot", arprot, chseq[i] ? 3'b000 : 3'b100);
            chk("arb.araddr", araddr, chseq[i] ? 32'h20 : 32'h10);
            chk("arb.busy", {f_ready, d_ready}, 2'b00);
            tick();
            rvalid = 1'b1; rdata = 32'h1000 + i;
            tick();
            rvalid = 1'b0; f_valid = 1'b0; d_valid = 1'b0;
            chk("arb.resp_ch", {resp_valid, resp_ch}, {1'b1, chseq[i]});
            chk("arb.resp_rdata", resp_rdata, 32'h1000 + i);
            tick();
        end

        // Read timeout: rready high 4 cycles in R, then err 11.
        f_valid = 1'b1; f_addr = 32'h40;
        tick();
        f_valid = 1'b0;
        chk("to.arvalid", arvalid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to.rready", rready, 1'b1);
        end
        tick();
        chk("to.drop", {rready, resp_valid}, 2'b00);
        tick();
        chk("to.resp", {resp_valid, resp_ch, resp_err}, 4'b1011);
        chk("to.rdata", resp_rdata, 32'h0);
        tick();
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        tick();
        rvalid = 1'b0;
        chk("to.late", {rready, resp_valid}, 2'b00);

        // Reset in the middle of a store address/data phase.
        d_valid = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_size = 2'b10; d_wdata = 32'hA5A5_A5A5;
        tick();
        d_valid = 1'b0; d_we = 1'b0;
        chk("rst.aw_w", {awvalid, wvalid}, 2'b11);
        rstn = 1'b0;
        tick();
        chk("rst.aw_w_low", {awvalid, wvalid, resp_valid}, 3'b000);
        rstn = 1'b1;
        tick();

        // Reset during a stalled fetch must restore the fetch preference.
        arready = 1'b0;
        f_valid = 1'b1; f_addr = 32'h50;
        tick();
        f_valid = 1'b0;
        chk("rst2.arvalid", arvalid, 1'b1);
        rstn = 1'b0;
        tick();
        chk("rst2.arvalid_low", arvalid, 1'b0);
        rstn = 1'b1; f_valid = 1'b1; d_valid = 1'b1; d_addr = 32'h20;
        #1;
        chk("rst2.pref", {f_ready, d_ready}, 2'b10);
        f_valid = 1'b0; d_valid = 1'b0;
        tick();
        tick();
        chk("rst2.idle", {arvalid, resp_valid}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
